redmule_tcdm_arbiter: RTL and testbench

Round-robin arbiter that shares one wide HCI-style TCDM master port between `N_REQ` wide requesters, e.g. the RedMulE streamer and a second DMA-like client. It sits between the requesters and the wide port that is later split into `DW/32` 32-bit banks. It tracks outstanding transactions in an in-order ID FIFO, so every TCDM response is returned to the requester that issued it.

---
 rtl/redmule_pkg.sv | 17 +
 rtl/redmule_arb_id_fifo.sv | 67 ++++++
 rtl/redmule_tcdm_arbiter.sv | 143 ++++++++++++++
 tb/tb_redmule_tcdm_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// ---------------------------------------------------------------------------
// redmule_pkg
// Shared RedMulE constants and types used by the TCDM arbiter slice.
//   DATA_W        : default wide-port data width (multiple of 32)
//   ARB_N_REQ     : default number of arbiter requesters
//   ARB_MAX_OUTST : default number of granted-but-unanswered transactions
//   arb_id_t      : requester index stored in the arbiter's ID FIFO
// ---------------------------------------------------------------------------
package redmule_pkg;

   localparam int unsigned DATA_W        = 256;
   localparam int unsigned ARB_N_REQ     = 2;
   localparam int unsigned ARB_MAX_OUTST = 4;

   typedef logic [$clog2(ARB_N_REQ)-1:0] arb_id_t;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// redmule_arb_id_fifo
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, id      : enqueue id (ignored when full)
//   pop           : dequeue head (ignored when empty)
//   head          : ID of the oldest outstanding transaction
//   count         : number of stored IDs, 0..DEPTH
//   full, empty   : occupancy flags
// ---------------------------------------------------------------------------
module redmule_arb_id_fifo
   import redmule_pkg::*;
#(
   parameter int unsigned DEPTH = ARB_MAX_OUTST,
   parameter int unsigned IDW   = $bits(arb_id_t),
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push,
   input  logic [IDW-1:0] id,
   input  logic           pop,
   output logic [IDW-1:0] head,
   output logic [CW-1:0]  count,
   output logic           full,
   output logic           empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDW-1:0] mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= id;
            wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// ---------------------------------------------------------------------------
// redmule_tcdm_arbiter
// Round-robin arbiter sharing one wide TCDM master port between N_REQ wide
// requesters. Outstanding transactions are tracked in an in-order ID FIFO so
// each response is routed back to the requester that issued it.
// Optional feature: define REDMULE_ARB_LOCK_EN to let lock_i[winner] keep the
// round-robin pointer on the winner (burst lock). Otherwise lock_i is ignored.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   req_i/gnt_o                    : per-requester request / grant
//   add_i/wen_i/be_i/data_i/lock_i : per-requester payload (wen 1 = read)
//   r_valid_o, r_data_o            : routed response valid, broadcast data
//   tcdm_*                         : wide master request/response channel
//   err_o                          : sticky, response with nothing outstanding
//   busy_o                         : transactions outstanding
// ---------------------------------------------------------------------------
module redmule_tcdm_arbiter
   import redmule_pkg::*;
#(
   parameter int unsigned N_REQ     = ARB_N_REQ,
   parameter int unsigned DW        = DATA_W,
   parameter int unsigned MAX_OUTST = ARB_MAX_OUTST
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [N_REQ-1:0]          req_i,
   output logic [N_REQ-1:0]          gnt_o,
   input  logic [N_REQ-1:0][31:0]    add_i,
   input  logic [N_REQ-1:0]          wen_i,
   input  logic [N_REQ-1:0][DW/8-1:0] be_i,
   input  logic [N_REQ-1:0][DW-1:0]  data_i,
   input  logic [N_REQ-1:0]          lock_i,
   output logic [N_REQ-1:0]          r_valid_o,
   output logic [DW-1:0]             r_data_o,
   output logic                      tcdm_req_o,
   input  logic                      tcdm_gnt_i,
   output logic [31:0]               tcdm_add_o,
   output logic                      tcdm_wen_o,
   output logic [DW/8-1:0]           tcdm_be_o,
   output logic [DW-1:0]             tcdm_data_o,
   input  logic                      tcdm_r_valid_i,
   input  logic [DW-1:0]             tcdm_r_data_i,
   output logic                      err_o,
   output logic                      busy_o
);

   localparam int unsigned IDW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW  = $clog2(MAX_OUTST + 1);

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] winner, cand, next_ptr;
   logic           any_req, hs, lock_win;
   logic           err_q;
   logic [IDW-1:0] fifo_head;
   logic [CW-1:0]  fifo_count;
   logic           fifo_full, fifo_empty;

   // First requesting index scanning upward from rr_ptr, modulo N_REQ.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IDW'((32'(rr_ptr_q) + i) % N_REQ);
         if (!any_req && req_i[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   // Full blocks new requests even if a response pops this cycle.
   assign tcdm_req_o = any_req & ~fifo_full;
   assign hs         = tcdm_req_o & tcdm_gnt_i;

   // Grant and payload mux.
   always_comb begin
      gnt_o       = '0;
      tcdm_add_o  = '0;
      tcdm_wen_o  = 1'b1;
      tcdm_be_o   = '0;
      tcdm_data_o = '0;
      if (hs) gnt_o[winner] = 1'b1;
      if (any_req) begin
         tcdm_add_o  = add_i[winner];
         tcdm_wen_o  = wen_i[winner];
         tcdm_be_o   = be_i[winner];
         tcdm_data_o = data_i[winner];
      end
   end

   // Response routing to the oldest outstanding requester.
   always_comb begin
      r_valid_o = '0;
      if (tcdm_r_valid_i && !fifo_empty) r_valid_o[fifo_head] = 1'b1;
   end
   assign r_data_o = tcdm_r_data_i;

`ifdef REDMULE_ARB_LOCK_EN
   assign lock_win = lock_i[winner];
`else
   logic unused_lock;
   assign unused_lock = ^lock_i;
   assign lock_win    = 1'b0;
`endif

   assign next_ptr = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (hs) rr_ptr_d = lock_win ? winner : next_ptr;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_q | (tcdm_r_valid_i & fifo_empty);
      end
   end

   assign err_o  = err_q;
   assign busy_o = (fifo_count != '0);

   redmule_arb_id_fifo #(
      .DEPTH (MAX_OUTST),
      .IDW   (IDW),
      .CW    (CW)
   ) u_id_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (hs),
      .id     (winner),
      .pop    (tcdm_r_valid_i),
      .head   (fifo_head),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_redmule_tcdm_arbiter
// Directed bench for the round-robin TCDM arbiter with hand-computed
// expectations: alternation, outstanding limit, push/pop, lock, spurious
// responses and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_redmule_tcdm_arbiter;

   localparam int unsigned N_REQ     = 2;
   localparam int unsigned DW        = 64;
   localparam int unsigned MAX_OUTST = 4;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [N_REQ-1:0]          req_i;
   logic [N_REQ-1:0]          gnt_o;
   logic [N_REQ-1:0][31:0]    add_i;
   logic [N_REQ-1:0]          wen_i;
   logic [N_REQ-1:0][DW/8-1:0] be_i;
   logic [N_REQ-1:0][DW-1:0]  data_i;
   logic [N_REQ-1:0]          lock_i;
   logic [N_REQ-1:0]          r_valid_o;
   logic [DW-1:0]             r_data_o;
   logic                      tcdm_req_o;
   logic                      tcdm_gnt_i;
   logic [31:0]               tcdm_add_o;
   logic                      tcdm_wen_o;
   logic [DW/8-1:0]           tcdm_be_o;
   logic [DW-1:0]             tcdm_data_o;
   logic                      tcdm_r_valid_i;
   logic [DW-1:0]             tcdm_r_data_i;
   logic                      err_o;
   logic                      busy_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] exp_seq;

   always #5 clk = ~clk;

   redmule_tcdm_arbiter #(
      .N_REQ     (N_REQ),
      .DW        (DW),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .add_i          (add_i),
      .wen_i          (wen_i),
      .be_i           (be_i),
      .data_i         (data_i),
      .lock_i         (lock_i),
      .r_valid_o      (r_valid_o),
      .r_data_o       (r_data_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .err_o          (err_o),
      .busy_o         (busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_i          = '0;
      lock_i         = '0;
      tcdm_gnt_i     = 1'b0;
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      add_i[0]  = 32'h100;
      add_i[1]  = 32'h200;
      data_i[0] = 64'hA0;
      data_i[1] = 64'hB1;
      be_i      = '1;
      wen_i     = 2'b11;
      idle_inputs();
      #2;
      // reset state
      check("rst_gnt", 64'(gnt_o), 64'h0);
      check("rst_rvalid", 64'(r_valid_o), 64'h0);
      check("rst_err", 64'(err_o), 64'h0);
      check("rst_busy", 64'(busy_o), 64'h0);
      check("rst_req", 64'(tcdm_req_o), 64'h0);
      check("rst_wen", 64'(tcdm_wen_o), 64'h1);
      check("rst_add", 64'(tcdm_add_o), 64'h0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // round-robin alternation, responses two cycles behind grants
      for (int cyc = 0; cyc < 6; cyc++) begin
         req_i          = (cyc < 4) ? 2'b11 : 2'b00;
         tcdm_gnt_i     = (cyc < 4);
         tcdm_r_valid_i = (cyc >= 2);
         tcdm_r_data_i  = 64'hD0 + 64'(cyc);
         #1;
         if (cyc < 4) begin
            check("rr_gnt", 64'(gnt_o), (cyc % 2 == 1) ? 64'h2 : 64'h1);
            check("rr_add", 64'(tcdm_add_o), (cyc % 2 == 1) ? 64'h200 : 64'h100);
         end
         if (cyc >= 2) begin
            check("rr_rvalid", 64'(r_valid_o), ((cyc - 2) % 2 == 1) ? 64'h2 : 64'h1);
            check("rr_rdata", r_data_o, 64'hD0 + 64'(cyc));
         end
         tick();
         if (cyc == 2) check("pushpop_count", 64'(dut.fifo_count), 64'h2);
      end
      idle_inputs();
      #1;
      check("rr_busy_end", 64'(busy_o), 64'h0);
      check("rr_ptr_end", 64'(dut.rr_ptr_q), 64'h0);

      // outstanding limit with requester 0 only
      req_i      = 2'b01;
      tcdm_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("lim_gnt", 64'(gnt_o), 64'h1);
         check("lim_req", 64'(tcdm_req_o), 64'h1);
         tick();
      end
      #1;
      check("full_req", 64'(tcdm_req_o), 64'h0);
      check("full_gnt", 64'(gnt_o), 64'h0);
      check("full_busy", 64'(busy_o), 64'h1);
      check("full_count", 64'(dut.fifo_count), 64'h4);
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = 64'hE0;
      #1;
      check("full_pop_req", 64'(tcdm_req_o), 64'h0);
      check("full_pop_rvalid", 64'(r_valid_o), 64'h1);
      tick();
      tcdm_r_valid_i = 1'b0;
      #1;
      check("refill_req", 64'(tcdm_req_o), 64'h1);
      check("refill_gnt", 64'(gnt_o), 64'h1);
      tick();
      req_i      = 2'b00;
      tcdm_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tcdm_r_valid_i = 1'b1;
         #1;
         check("lim_drain_rvalid", 64'(r_valid_o), 64'h1);
         tick();
      end
      tcdm_r_valid_i = 1'b0;
      #1;
      check("lim_busy_end", 64'(busy_o), 64'h0);
      check("lim_ptr_end", 64'(dut.rr_ptr_q), 64'h1);

      // burst lock on requester 1, dropped during its third grant
`ifdef REDMULE_ARB_LOCK_EN
      exp_seq = 4'b0111;
`else
      exp_seq = 4'b0101;
`endif
      req_i      = 2'b11;
      tcdm_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         lock_i = (k < 2) ? 2'b10 : 2'b00;
         #1;
         check("lock_gnt", 64'(gnt_o), exp_seq[k] ? 64'h2 : 64'h1);
         tick();
      end
      req_i      = 2'b00;
      lock_i     = 2'b00;
      tcdm_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tcdm_r_valid_i = 1'b1;
         #1;
         check("lock_rvalid", 64'(r_valid_o), exp_seq[k] ? 64'h2 : 64'h1);
         tick();
      end
      tcdm_r_valid_i = 1'b0;

      // spurious response with empty FIFO
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = 64'hF0;
      #1;
      check("spur_rvalid", 64'(r_valid_o), 64'h0);
      check("spur_err_pre", 64'(err_o), 64'h0);
      tick();
      tcdm_r_valid_i = 1'b0;
      check("spur_err", 64'(err_o), 64'h1);
      check("spur_count", 64'(dut.fifo_count), 64'h0);
      tick();
      tick();
      check("spur_err_held", 64'(err_o), 64'h1);

      // reset with three transactions outstanding
      req_i      = 2'b01;
      tcdm_gnt_i = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      req_i      = 2'b00;
      tcdm_gnt_i = 1'b0;
      #1;
      check("mid_count", 64'(dut.fifo_count), 64'h3);
      check("mid_busy", 64'(busy_o), 64'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_count", 64'(dut.fifo_count), 64'h0);
      check("mid_rst_busy", 64'(busy_o), 64'h0);
      check("mid_rst_ptr", 64'(dut.rr_ptr_q), 64'h0);
      check("mid_rst_err", 64'(err_o), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tcdm_r_valid_i = 1'b1;
      #1;
      check("post_rst_rvalid", 64'(r_valid_o), 64'h0);
      tick();
      tcdm_r_valid_i = 1'b0;
      check("post_rst_err", 64'(err_o), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
